// File: rtl/dummy_hls_ip_package.sv
// Shared types and constants for the dummy HLS IP micro-loop iterator.
// Optional DUMMY_HLS_IP_ULOOP_IDX_EN adds idx_inner/idx_outer to flags_uloop_t.
package dummy_hls_ip_package;

  localparam int unsigned ULOOP_NB_STREAMS = 2;
  localparam int unsigned ULOOP_OFFS_W     = 32;
  localparam int unsigned ULOOP_CNT_W      = 16;

  localparam int unsigned MAC_UCODE_ch_fpga_func0_graph_input_0_OFFS = 0;
  localparam int unsigned MAC_UCODE_ch_fpga_func0_output0_OFFS       = 1;

  typedef struct packed {
    logic enable;
    logic clear;
    logic ready;
  } ctrl_uloop_t;

  typedef struct packed {
    logic [ULOOP_CNT_W-1:0]                        n_inner;
    logic [ULOOP_CNT_W-1:0]                        n_outer;
    logic [ULOOP_NB_STREAMS-1:0][ULOOP_OFFS_W-1:0] stride_inner;
    logic [ULOOP_NB_STREAMS-1:0][ULOOP_OFFS_W-1:0] stride_outer;
  } uloop_cfg_t;

  typedef struct packed {
    logic [ULOOP_NB_STREAMS-1:0][ULOOP_OFFS_W-1:0] offs;
    logic                                          valid;
    logic                                          done;
`ifdef DUMMY_HLS_IP_ULOOP_IDX_EN
    logic [ULOOP_CNT_W-1:0]                        idx_inner;
    logic [ULOOP_CNT_W-1:0]                        idx_outer;
`endif
  } flags_uloop_t;

  typedef enum logic [1:0] {
    ULOOP_VALID,
    ULOOP_TAKEN,
    ULOOP_DONE
  } uloop_state_e;

endpackage

// File: rtl/dummy_hls_ip_uloop_acc.sv
// Per-stream offset accumulator: current offset plus start-of-row offset,
// both advanced incrementally by the inner/outer strides.
module dummy_hls_ip_uloop_acc #(
  parameter int unsigned OFFS_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              step_inner_i,
  input  logic              step_row_i,
  input  logic [OFFS_W-1:0] stride_inner_i,
  input  logic [OFFS_W-1:0] stride_outer_i,
  output logic [OFFS_W-1:0] offs_o
);

  logic [OFFS_W-1:0] acc_row_q;
  logic [OFFS_W-1:0] offs_q;
  logic [OFFS_W-1:0] row_next;

  assign row_next = acc_row_q + stride_outer_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_row_q <= '0;
      offs_q    <= '0;
    end else if (clr_i) begin
      acc_row_q <= '0;
      offs_q    <= '0;
    end else if (step_row_i) begin
      acc_row_q <= row_next;
      offs_q    <= row_next;
    end else if (step_inner_i) begin
      offs_q    <= offs_q + stride_inner_i;
    end
  end

  assign offs_o = offs_q;

endmodule

// File: rtl/dummy_hls_ip_uloop.sv
// Two-level micro-loop offset iterator driving flags_uloop for the HWPE FSM.
// Define DUMMY_HLS_IP_ULOOP_IDX_EN to expose idx_inner/idx_outer in flags_o.
module dummy_hls_ip_uloop
  import dummy_hls_ip_package::*;
#(
  parameter int unsigned NB_STREAMS = ULOOP_NB_STREAMS,
  parameter int unsigned OFFS_W     = ULOOP_OFFS_W,
  parameter int unsigned CNT_W      = ULOOP_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         test_mode_i,
  input  logic         clear_i,
  input  ctrl_uloop_t  ctrl_i,
  input  uloop_cfg_t   cfg_i,
  output flags_uloop_t flags_o
);

  uloop_state_e state_q, state_d;
  logic [CNT_W-1:0] idx_inner_q, idx_outer_q;
  logic [CNT_W-1:0] n_inner_eff, n_outer_eff;
  logic             clr, last_inner, last_outer;
  logic             step_inner, step_row;
  logic             unused_test_mode;
  logic [NB_STREAMS-1:0][OFFS_W-1:0] offs;

  assign unused_test_mode = test_mode_i;
  assign clr = clear_i | ctrl_i.clear;

  // A zero count behaves as one so the loop always yields at least one iteration.
  assign n_inner_eff = (cfg_i.n_inner == '0) ? CNT_W'(1) : cfg_i.n_inner;
  assign n_outer_eff = (cfg_i.n_outer == '0) ? CNT_W'(1) : cfg_i.n_outer;
  assign last_inner  = (idx_inner_q == n_inner_eff - CNT_W'(1));
  assign last_outer  = (idx_outer_q == n_outer_eff - CNT_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ULOOP_VALID;
    end else if (clr) begin
      state_q <= ULOOP_VALID;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_inner = 1'b0;
    step_row   = 1'b0;
    unique case (state_q)
      ULOOP_VALID: if (ctrl_i.ready) state_d = ULOOP_TAKEN;
      ULOOP_TAKEN: begin
        if (ctrl_i.enable) begin
          if (!last_inner) begin
            step_inner = 1'b1;
            state_d    = ULOOP_VALID;
          end else if (!last_outer) begin
            step_row   = 1'b1;
            state_d    = ULOOP_VALID;
          end else begin
            state_d    = ULOOP_DONE;
          end
        end
      end
      ULOOP_DONE:  state_d = ULOOP_DONE;
      default:     state_d = ULOOP_VALID;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_inner_q <= '0;
      idx_outer_q <= '0;
    end else if (clr) begin
      idx_inner_q <= '0;
      idx_outer_q <= '0;
    end else if (step_row) begin
      idx_inner_q <= '0;
      idx_outer_q <= idx_outer_q + CNT_W'(1);
    end else if (step_inner) begin
      idx_inner_q <= idx_inner_q + CNT_W'(1);
    end
  end

  for (genvar s = 0; s < NB_STREAMS; s++) begin : gen_acc
    dummy_hls_ip_uloop_acc #(
      .OFFS_W(OFFS_W)
    ) i_acc (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clr_i         (clr),
      .step_inner_i  (step_inner && !clr),
      .step_row_i    (step_row && !clr),
      .stride_inner_i(cfg_i.stride_inner[s]),
      .stride_outer_i(cfg_i.stride_outer[s]),
      .offs_o        (offs[s])
    );
  end

  always_comb begin
    flags_o       = '0;
    flags_o.offs  = offs;
    flags_o.valid = (state_q != ULOOP_TAKEN);
    flags_o.done  = (state_q == ULOOP_DONE);
`ifdef DUMMY_HLS_IP_ULOOP_IDX_EN
    flags_o.idx_inner = idx_inner_q;
    flags_o.idx_outer = idx_outer_q;
`endif
  end

endmodule

// File: tb/tb_dummy_hls_ip_uloop.sv
// Directed self-checking bench for dummy_hls_ip_uloop with hand-computed expectations.
module tb_dummy_hls_ip_uloop;
  import dummy_hls_ip_package::*;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         test_mode_i = 1'b0;
  logic         clear_i = 1'b0;
  ctrl_uloop_t  ctrl = '0;
  uloop_cfg_t   cfg = '0;
  flags_uloop_t flags;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] exp0 [6] = '{32'd0, 32'd4, 32'd8, 32'd100, 32'd104, 32'd108};
  logic [31:0] exp1 [6] = '{32'd0, 32'd8, 32'd16, 32'd200, 32'd208, 32'd216};

  dummy_hls_ip_uloop #(
    .NB_STREAMS(2),
    .OFFS_W    (32),
    .CNT_W     (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .test_mode_i(test_mode_i),
    .clear_i    (clear_i),
    .ctrl_i     (ctrl),
    .cfg_i      (cfg),
    .flags_o    (flags)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic consume();
    ctrl.ready = 1'b1;
    cyc();
    ctrl.ready = 1'b0;
  endtask

  task automatic advance();
    ctrl.enable = 1'b1;
    cyc();
    ctrl.enable = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_offs0"}, flags.offs[0], 32'd0);
    chk({tag, "_offs1"}, flags.offs[1], 32'd0);
    chk({tag, "_valid"}, 32'(flags.valid), 32'd1);
    chk({tag, "_done"},  32'(flags.done), 32'd0);
`ifdef DUMMY_HLS_IP_ULOOP_IDX_EN
    chk({tag, "_idx_in"},  32'(flags.idx_inner), 32'd0);
    chk({tag, "_idx_out"}, 32'(flags.idx_outer), 32'd0);
`endif
  endtask

  task automatic cfg_3x2();
    cfg = '0;
    cfg.n_inner = 16'd3;
    cfg.n_outer = 16'd2;
    cfg.stride_inner[0] = 32'd4;
    cfg.stride_inner[1] = 32'd8;
    cfg.stride_outer[0] = 32'd100;
    cfg.stride_outer[1] = 32'd200;
  endtask

  initial begin
    // Reset, then a synchronous clear with nothing else going on
    cfg_3x2();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk_reset("reset");
    do_clear();
    chk_reset("clear");

    // Full 3x2 walk with consume/advance handshakes
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("walk%0d_offs0", k), flags.offs[0], exp0[k]);
      chk($sformatf("walk%0d_offs1", k), flags.offs[1], exp1[k]);
      chk($sformatf("walk%0d_valid", k), 32'(flags.valid), 32'd1);
      chk($sformatf("walk%0d_done", k),  32'(flags.done), 32'd0);
      consume();
      chk($sformatf("walk%0d_taken", k), 32'(flags.valid), 32'd0);
      advance();
    end
    chk("walk_done",       32'(flags.done), 32'd1);
    chk("walk_done_valid", 32'(flags.valid), 32'd1);
    chk("walk_done_offs0", flags.offs[0], 32'd108);
    chk("walk_done_offs1", flags.offs[1], 32'd216);
`ifdef DUMMY_HLS_IP_ULOOP_IDX_EN
    chk("walk_done_idx_in",  32'(flags.idx_inner), 32'd2);
    chk("walk_done_idx_out", 32'(flags.idx_outer), 32'd1);
`endif

    // Inputs after done are ignored
    consume();
    advance();
    chk("hold_done",  32'(flags.done), 32'd1);
    chk("hold_valid", 32'(flags.valid), 32'd1);
    chk("hold_offs0", flags.offs[0], 32'd108);

    // Clear from ctrl while done
    ctrl.clear = 1'b1;
    cyc();
    ctrl.clear = 1'b0;
    chk_reset("clr_done");

    // Clear mid-run after iteration 4
    for (int k = 0; k < 4; k++) begin
      consume();
      advance();
    end
    chk("mid_offs0", flags.offs[0], 32'd104);
    chk("mid_offs1", flags.offs[1], 32'd208);
    do_clear();
    chk_reset("clr_mid");

    // Enable while valid is ignored; held ready drops valid only once
    ctrl.enable = 1'b1;
    repeat (3) cyc();
    ctrl.enable = 1'b0;
    chk("en_hold_offs0", flags.offs[0], 32'd0);
    chk("en_hold_valid", 32'(flags.valid), 32'd1);
    ctrl.ready = 1'b1;
    repeat (10) cyc();
    ctrl.ready = 1'b0;
    chk("rdy_hold_valid", 32'(flags.valid), 32'd0);
    advance();
    chk("rdy_hold_offs0", flags.offs[0], 32'd4);
    chk("rdy_hold_offs1", flags.offs[1], 32'd8);
    chk("rdy_hold_valid2", 32'(flags.valid), 32'd1);

    // Zero counts mean a single iteration
    cfg.n_inner = 16'd0;
    cfg.n_outer = 16'd0;
    do_clear();
    chk_reset("zero_start");
    consume();
    advance();
    chk("zero_done",  32'(flags.done), 32'd1);
    chk("zero_offs0", flags.offs[0], 32'd0);

    // Silent wrap-around of the inner stride
    cfg = '0;
    cfg.n_inner = 16'd3;
    cfg.n_outer = 16'd1;
    cfg.stride_inner[0] = 32'hFFFF_FFFC;
    do_clear();
    chk("wrap0", flags.offs[0], 32'h0000_0000);
    consume();
    advance();
    chk("wrap1", flags.offs[0], 32'hFFFF_FFFC);
    consume();
    advance();
    chk("wrap2", flags.offs[0], 32'hFFFF_FFF8);
    chk("wrap2_done", 32'(flags.done), 32'd0);
    consume();
    advance();
    chk("wrap_done", 32'(flags.done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dummy_hls_ip_uloop.md
# dummy_hls_ip_uloop

Micro-loop offset iterator for the dummy HLS IP HWPE. It sits beside the control FSM and drives the `flags_uloop` bundle: a per-stream byte offset that the FSM adds to each stream base address, plus `valid` and `done`. It walks a two-level (outer × inner) loop with per-stream strides. Offsets are accumulated incrementally, so the block uses no multipliers.

## Interface
Parameters:
- NB_STREAMS, 2: number of offset channels. Index 0 is graph_input_0, index 1 is output0.
- OFFS_W, 32: offset width in bytes.
- CNT_W, 16: loop counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- test_mode_i  in  1  unused; present for HWPE uniformity.
- clear_i  in  1  synchronous global clear.
- ctrl_i  in  ctrl_uloop_t  {enable, clear, ready} from the FSM.
- cfg_i  in  uloop_cfg_t  {n_inner, n_outer (CNT_W each); stride_inner[NB_STREAMS], stride_outer[NB_STREAMS] (OFFS_W each)}. Must be held stable while not clearing.
- flags_o  out  flags_uloop_t  {offs[NB_STREAMS] (OFFS_W), valid, done, plus idx_inner/idx_outer only when DUMMY_HLS_IP_ULOOP_IDX_EN is defined}.

## Operation
- State registers:
  - i (inner index), j (outer index).
  - acc_row[s]: offset at the start of the current outer row.
  - offs[s]: current offset.
  - valid, done.
- Reset / clear: i=j=0, acc_row=offs=0, valid=1, done=0.
  - Clear comes from rst_ni, clear_i or ctrl_i.clear.
  - The first iteration (offset 0) is valid immediately.
- Consume: ctrl_i.ready=1 while valid=1 and done=0 → valid←0 next cycle.
  - Marks the current offsets as taken.
  - Repeated ready pulses while valid=0 have no effect.
- Advance: ctrl_i.enable=1 while valid=0 and done=0. Next cycle:
  - If i<n_inner−1: i←i+1; offs[s]←offs[s]+stride_inner[s]; valid←1.
  - Else if j<n_outer−1: i←0; j←j+1; acc_row[s]←acc_row[s]+stride_outer[s]; offs[s]←acc_row[s]+stride_outer[s]; valid←1.
  - Else (last iteration): done←1 and valid←1; offs and indices hold.
- Effective counts: n_inner=0 or n_outer=0 is treated as 1, i.e. a single iteration.
- Arithmetic: all additions are unsigned modulo 2^OFFS_W; wrap-around is silent.
- Priority and ignored inputs:
  - Clear beats consume/advance.
  - enable while valid=1 is ignored.
  - Consume and advance cannot coincide, because valid gates them.
- After done: outputs hold (done=1, valid=1) until a clear. enable and ready are ignored.
- Clear mid-loop (including while done=1) returns to the reset state in the next cycle.
- Total sequence: exactly n_inner·n_outer valid offsets, followed by one done assertion.

## Timing
- All outputs are registered; there is no combinational path from ctrl_i or cfg_i to flags_o.
- Reset values: offs=0, valid=1, done=0, idx=0.
- Latency:
  - Consume → valid low: 1 cycle.
  - Advance → new offs/valid/done: 1 cycle.
- FSM interaction: in UPDATEIDX the FSM sees valid=0 and pulses enable. The cycle after, it sees valid=1 and either done=1 (terminate) or new offsets (start the streamers).
- Throughput: one iteration per 2 handshake cycles minimum (consume, then advance).

## Configuration
- DUMMY_HLS_IP_ULOOP_IDX_EN defined: flags_o carries idx_inner/idx_outer (CNT_W each), equal to the registered i and j. This is for debug and for per-row engine control.
- Undefined: those fields and their registers are absent. The offs/valid/done behaviour is identical in both builds.

## Structure
- dummy_hls_ip_package holds:
  - ctrl_uloop_t, flags_uloop_t, uloop_cfg_t;
  - constants ULOOP_NB_STREAMS, ULOOP_OFFS_W, ULOOP_CNT_W;
  - the stream index constants MAC_UCODE_ch_fpga_func0_graph_input_0_OFFS=0 and MAC_UCODE_ch_fpga_func0_output0_OFFS=1.
- One sub-module, dummy_hls_ip_uloop_acc: the per-stream offset/row accumulator pair, instantiated NB_STREAMS times via generate.
- Loop counters and the valid/done control stay in the top module.

## Test plan
- Reset then clear: after rst_ni rises → offs={0,0}, valid=1, done=0 with no stimulus.
- n_inner=3, n_outer=2, stride_inner={4,8}, stride_outer={100,200}, full consume/advance handshake:
  - offs[0] sequence: 0, 4, 8, 100, 104, 108.
  - offs[1] sequence: 0, 8, 16, 200, 208, 216.
  - Then done=1 exactly after the 6th advance.
- n_inner=0, n_outer=0: consume then advance → done=1 on the first advance.
- enable held while valid=1: offs unchanged, no skipped iteration. Likewise, ready held for 10 cycles drops valid only once.
- Wrap: stride_inner[0]=32'hFFFF_FFFC with n_inner=3 → offs[0]: 0, FFFF_FFFC, FFFF_FFF8.
- Clear mid-run (after iteration 4 of 6), and clear while done=1: next cycle offs=0, valid=1, done=0. Idx fields are 0 when DUMMY_HLS_IP_ULOOP_IDX_EN is defined.
